// File: rtl/pe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pe_pkg -- state encoding and defaults shared by the PE sequencer. Rev 1.0
// ----------------------------------------------------------------------------
package pe_pkg;

  localparam int PE_LATENCY_DEFAULT = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCUM  = 3'd1;
  localparam logic [2:0] ST_FORMAT = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  // States in which a new operand pair may be taken.
  function automatic logic st_accepts(input logic [2:0] st);
    return (st == ST_IDLE) || (st == ST_ACCUM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_sequencer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pe_sequencer_if -- operand-pair input stream and result stream. Rev 1.0
// ----------------------------------------------------------------------------
interface pe_sequencer_if #(
  parameter int WIDTH_DATA = 16,
  parameter int WIDTH_CNT  = 8
);

  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [WIDTH_DATA-1:0] in_a_i;
  logic [WIDTH_DATA-1:0] in_b_i;
  logic                  in_last_i;

  logic                  res_valid_o;
  logic                  res_ready_i;
  logic [WIDTH_DATA-1:0] res_data_o;
  logic [WIDTH_CNT-1:0]  res_len_o;
  logic                  res_ovf_o;

  modport slave (
    input  in_valid_i, in_a_i, in_b_i, in_last_i, res_ready_i,
    output in_ready_o, res_valid_o, res_data_o, res_len_o, res_ovf_o
  );

  modport master (
    output in_valid_i, in_a_i, in_b_i, in_last_i, res_ready_i,
    input  in_ready_o, res_valid_o, res_data_o, res_len_o, res_ovf_o
  );

endinterface
`default_nettype wire

// File: rtl/pe_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pe_sequencer -- feeds operand pairs to a MAC PE, formats and returns result.
// Rev 1.0
// ----------------------------------------------------------------------------
module pe_sequencer
  import pe_pkg::*;
#(
  parameter int WIDTH_DATA = 16,
  parameter int PE_LATENCY = PE_LATENCY_DEFAULT,
  parameter int WIDTH_CNT  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  pe_sequencer_if.slave         bus,
  output logic [WIDTH_DATA-1:0] data_a_o,
  output logic [WIDTH_DATA-1:0] data_b_o,
  output logic                  keep_data_o,
  output logic                  format_en_o,
  input  logic [WIDTH_DATA-1:0] pe_data_i
);

  localparam int WIDTH_LAT = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;
  localparam logic [WIDTH_LAT-1:0] LAT_LAST = WIDTH_LAT'(PE_LATENCY - 1);
  localparam logic [WIDTH_CNT-1:0] CNT_MAX  = '1;

  logic [2:0]            state_q, state_d;
  logic [WIDTH_CNT-1:0]  cnt_q, cnt_d;
  logic [WIDTH_LAT-1:0]  lat_q, lat_d;
  logic                  ovf_q, ovf_d;
  logic [WIDTH_DATA-1:0] a_q, a_d;
  logic [WIDTH_DATA-1:0] b_q, b_d;
  logic [WIDTH_DATA-1:0] res_q, res_d;
  logic                  keep_q, keep_d;
  logic                  fmt_q, fmt_d;
  logic                  valid_q, valid_d;

  logic w_ready_st;
  logic w_accept;
  logic w_cnt_full;
  logic w_last;

  // Ready is forced low while reset is held so nothing is taken mid-reset.
  assign w_ready_st     = st_accepts(state_q);
  assign bus.in_ready_o = w_ready_st & ~rst;
  assign w_accept       = bus.in_valid_i & w_ready_st;
  assign w_cnt_full     = (cnt_q == (CNT_MAX - 1'b1));
  assign w_last         = bus.in_last_i | w_cnt_full;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    valid_d = valid_q;
    a_d     = '0;
    b_d     = '0;
    keep_d  = 1'b0;
    fmt_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACCUM: begin
        // Inside a job every cycle accumulates, even bubbles (zero product).
        keep_d = (state_q == ST_ACCUM);
        if (w_accept) begin
          a_d   = bus.in_a_i;
          b_d   = bus.in_b_i;
          cnt_d = cnt_q + 1'b1;
          if (w_last) begin
            state_d = ST_FORMAT;
            ovf_d   = ~bus.in_last_i;
          end else begin
            state_d = ST_ACCUM;
          end
        end
      end
      ST_FORMAT: begin
        fmt_d   = 1'b1;
        lat_d   = LAT_LAST;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          res_d   = pe_data_i;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.res_ready_i) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      keep_q  <= 1'b0;
      fmt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      keep_q  <= keep_d;
      fmt_q   <= fmt_d;
    end
  end

  assign data_a_o        = a_q;
  assign data_b_o        = b_q;
  assign keep_data_o     = keep_q;
  assign format_en_o     = fmt_q;
  assign bus.res_valid_o = valid_q;
  assign bus.res_data_o  = res_q;
  assign bus.res_len_o   = cnt_q;
  assign bus.res_ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pe_sequencer -- directed self-checking bench for pe_sequencer. Rev 1.0
// ----------------------------------------------------------------------------
module tb_pe_sequencer;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_a_o;
  logic [15:0] data_b_o;
  logic        keep_data_o;
  logic        format_en_o;
  logic [15:0] pe_data_i;

  int          total = 0;
  int          bad = 0;
  logic [15:0] pe_val = 16'h0;
  int          pe_cnt = 0;

  pe_sequencer_if #(.WIDTH_DATA(16), .WIDTH_CNT(8)) u_if ();

  pe_sequencer #(.WIDTH_DATA(16), .PE_LATENCY(LAT), .WIDTH_CNT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (u_if),
    .data_a_o    (data_a_o),
    .data_b_o    (data_b_o),
    .keep_data_o (keep_data_o),
    .format_en_o (format_en_o),
    .pe_data_i   (pe_data_i)
  );

  always #5 clk = ~clk;

  // PE model: result valid only in the LAT-th cycle counting the pulse cycle.
  always @(negedge clk) begin
    if (rst) pe_cnt = 0;
    else if (format_en_o) pe_cnt = 1;
    else if (pe_cnt != 0 && pe_cnt <= LAT) pe_cnt = pe_cnt + 1;
    pe_data_i = (pe_cnt == LAT) ? pe_val : 16'hBAD0;
  end

  function automatic logic [33:0] pe_side();
    return {data_a_o, data_b_o, keep_data_o, format_en_o};
  endfunction

  function automatic logic [25:0] res_side();
    return {u_if.res_valid_o, u_if.res_data_o, u_if.res_len_o, u_if.res_ovf_o};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b, input logic l);
    u_if.in_valid_i = v;
    u_if.in_a_i     = a;
    u_if.in_b_i     = b;
    u_if.in_last_i  = l;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    u_if.res_ready_i = 1'b0;
    tick();
    tick();
    total++;
    if ({u_if.in_ready_o, pe_side(), res_side()} !== 61'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", {u_if.in_ready_o, pe_side(), res_side()});
    end
    rst = 1'b0;
    #1;
    total++;
    if (u_if.in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %b want 1", u_if.in_ready_o);
    end
  endtask

  task automatic test_four_pair();
    logic k;
    pe_val = 16'h001E;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'(i), 16'(i), (i == 4));
      k = (i != 1);
      tick();
      total++;
      if (pe_side() !== {16'(i), 16'(i), k, 1'b0}) begin
        bad++;
        $display("FAIL four_pair%0d: got %h want %h", i, pe_side(), {16'(i), 16'(i), k, 1'b0});
      end
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    total++;
    if (u_if.in_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL four_ready_in_format: got %b want 0", u_if.in_ready_o);
    end
    tick();
    total++;
    if (pe_side() !== {32'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL four_format: got %h want %h", pe_side(), {32'h0, 1'b0, 1'b1});
    end
    tick();
    total++;
    if (pe_side() !== 34'h0) begin
      bad++;
      $display("FAIL four_format_single: got %h want 0", pe_side());
    end
    tick();
    total++;
    if (res_side() !== {1'b1, 16'h001E, 8'd4, 1'b0}) begin
      bad++;
      $display("FAIL four_result: got %h want %h", res_side(), {1'b1, 16'h001E, 8'd4, 1'b0});
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (res_side() !== {1'b1, 16'h001E, 8'd4, 1'b0}) begin
        bad++;
        $display("FAIL four_hold%0d: got %h want %h", c, res_side(), {1'b1, 16'h001E, 8'd4, 1'b0});
      end
    end
    // Pair offered in the HOLD->IDLE cycle must be ignored.
    u_if.res_ready_i = 1'b1;
    drive(1'b1, 16'h9, 16'h9, 1'b1);
    total++;
    if (u_if.in_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_exit_ready: got %b want 0", u_if.in_ready_o);
    end
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    u_if.res_ready_i = 1'b0;
    total++;
    if ({u_if.res_valid_o, u_if.in_ready_o, data_a_o} !== {1'b0, 1'b1, 16'h0}) begin
      bad++;
      $display("FAIL hold_exit: got %h want %h", {u_if.res_valid_o, u_if.in_ready_o, data_a_o}, {1'b0, 1'b1, 16'h0});
    end
    tick();
    total++;
    if (format_en_o !== 1'b0) begin
      bad++;
      $display("FAIL hold_exit_no_job: got %b want 0", format_en_o);
    end
  endtask

  task automatic test_len1();
    pe_val = 16'h0019;
    drive(1'b1, 16'h5, 16'h5, 1'b1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    total++;
    if (pe_side() !== {16'h5, 16'h5, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL len1_pair: got %h want %h", pe_side(), {16'h5, 16'h5, 1'b0, 1'b0});
    end
    tick();
    total++;
    if (pe_side() !== {32'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL len1_format: got %h want %h", pe_side(), {32'h0, 1'b0, 1'b1});
    end
    tick();
    tick();
    total++;
    if (res_side() !== {1'b1, 16'h0019, 8'd1, 1'b0}) begin
      bad++;
      $display("FAIL len1_result: got %h want %h", res_side(), {1'b1, 16'h0019, 8'd1, 1'b0});
    end
    u_if.res_ready_i = 1'b1;
    tick();
    u_if.res_ready_i = 1'b0;
  endtask

  task automatic test_gapped();
    logic [15:0] ga [5] = '{16'd2, 16'd0, 16'd4, 16'd0, 16'd6};
    logic [15:0] gb [5] = '{16'd3, 16'd0, 16'd5, 16'd0, 16'd7};
    logic        gv [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        gk [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    pe_val = 16'h0044;
    for (int i = 0; i < 5; i++) begin
      drive(gv[i], ga[i], gb[i], (i == 4));
      tick();
      total++;
      if (pe_side() !== {ga[i], gb[i], gk[i], 1'b0}) begin
        bad++;
        $display("FAIL gapped%0d: got %h want %h", i, pe_side(), {ga[i], gb[i], gk[i], 1'b0});
      end
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    total++;
    if (format_en_o !== 1'b1) begin
      bad++;
      $display("FAIL gapped_format: got %b want 1", format_en_o);
    end
    tick();
    tick();
    total++;
    if (res_side() !== {1'b1, 16'h0044, 8'd3, 1'b0}) begin
      bad++;
      $display("FAIL gapped_result: got %h want %h", res_side(), {1'b1, 16'h0044, 8'd3, 1'b0});
    end
    u_if.res_ready_i = 1'b1;
    tick();
    u_if.res_ready_i = 1'b0;
  endtask

  task automatic test_overflow();
    int miss = 0;
    pe_val = 16'h00FF;
    for (int i = 1; i <= 255; i++) begin
      drive(1'b1, 16'h1, 16'h2, 1'b0);
      if (u_if.in_ready_o !== 1'b1 || format_en_o !== 1'b0) miss++;
      tick();
    end
    drive(1'b1, 16'h9, 16'h9, 1'b0);
    total++;
    if (miss !== 0) begin
      bad++;
      $display("FAIL ovf_stream: got %0d stalls want 0", miss);
    end
    total++;
    if ({u_if.in_ready_o, data_a_o, keep_data_o} !== {1'b0, 16'h1, 1'b1}) begin
      bad++;
      $display("FAIL ovf_forced_last: got %h want %h", {u_if.in_ready_o, data_a_o, keep_data_o}, {1'b0, 16'h1, 1'b1});
    end
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    total++;
    if (pe_side() !== {32'h0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL ovf_format: got %h want %h", pe_side(), {32'h0, 1'b0, 1'b1});
    end
    tick();
    tick();
    total++;
    if (res_side() !== {1'b1, 16'h00FF, 8'd255, 1'b1}) begin
      bad++;
      $display("FAIL ovf_result: got %h want %h", res_side(), {1'b1, 16'h00FF, 8'd255, 1'b1});
    end
    u_if.res_ready_i = 1'b1;
    tick();
    u_if.res_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    int seen = 0;
    pe_val = 16'h0038;
    drive(1'b1, 16'h1, 16'h2, 1'b0);
    tick();
    drive(1'b1, 16'h3, 16'h4, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    total++;
    if (pe_side() !== {16'h3, 16'h4, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL midrst_pair2: got %h want %h", pe_side(), {16'h3, 16'h4, 1'b1, 1'b0});
    end
    rst = 1'b1;
    #1;
    total++;
    if ({u_if.in_ready_o, pe_side(), u_if.res_valid_o} !== 36'h0) begin
      bad++;
      $display("FAIL midrst_async: got %h want 0", {u_if.in_ready_o, pe_side(), u_if.res_valid_o});
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (u_if.in_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL midrst_release_ready: got %b want 1", u_if.in_ready_o);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (format_en_o !== 1'b0 || u_if.res_valid_o !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL midrst_abandon: got %0d stray strobes want 0", seen);
    end
    drive(1'b1, 16'h7, 16'h8, 1'b1);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    total++;
    if (pe_side() !== {16'h7, 16'h8, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_next_first: got %h want %h", pe_side(), {16'h7, 16'h8, 1'b0, 1'b0});
    end
    tick();
    tick();
    tick();
    total++;
    if (res_side() !== {1'b1, 16'h0038, 8'd1, 1'b0}) begin
      bad++;
      $display("FAIL midrst_next_result: got %h want %h", res_side(), {1'b1, 16'h0038, 8'd1, 1'b0});
    end
    u_if.res_ready_i = 1'b1;
    tick();
    u_if.res_ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_four_pair();
    test_len1();
    test_gapped();
    test_overflow();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
